alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 8-bit `alu`. It adds WIDTH-generic datapath, a full flag set (Zero/Carry/Overflow/Negative), shifts, SLT/NOR, and an iterative multiply. Operands enter through a valid/ready port and results leave through a registered valid/ready port. It sits between the instruction decode/operand stage and writeback. Ops and flags are aligned with a single output register.

## Interface
- WIDTH, 8, datapath width; power of two, ≥4
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)
- Clk  in  1  clock; all state changes on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- In_valid  in  1  operand/opcode valid
- In_ready  out  1  block can accept; transfer when In_valid && In_ready
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (low SHW bits = shift amount for shifts)
- Sel  in  4  opcode
- Out_valid  out  1  result valid; held until Out_ready
- Out_ready  in  1  consumer accepts result
- Out  out  WIDTH  result
- Zero  out  1  Out == 0
- Carry  out  1  carry/no-borrow/multiply-overflow (see Operation)
- Overflow  out  1  signed overflow, ADD/SUB only
- Negative  out  1  Out[WIDTH-1]
- Err  out  1  Sel was not a defined opcode

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 1100 NOR
  - 0010 ADD; 0110 SUB (A−B)
  - 0111 SLT: signed A<B → 1, else 0
  - 0011 SLL; 0100 SRL; 0101 SRA, each by B[SHW-1:0]
  - 1000 MUL: unsigned, low WIDTH bits of the product
- Any other Sel: Out=0, Zero=1, Err=1, other flags 0.
- Carry:
  - ADD: carry-out.
  - SUB: carry-out of A+~B+1, i.e. 1 when A≥B unsigned.
  - MUL: 1 when the high WIDTH product bits are nonzero.
  - All other ops: 0.
- Overflow: signed overflow for ADD/SUB; 0 otherwise.
- Zero and Negative are computed from the registered Out for every op, including Err.
- FSM states:
  - IDLE → single-cycle op: result and flags load into the output register at the accepting edge. State stays IDLE.
  - IDLE → MUL on accepting a MUL. Load multiplicand/multiplier and a WIDTH-count down-counter.
  - MUL: one shift-add step per cycle. When the counter reaches 0, load the output register and return to IDLE.
- In_ready = (state==IDLE) && (!Out_valid || Out_ready). Combinational; no combinational path from In_valid.
- Output register holds Out and all flags stable while Out_valid && !Out_ready.
- Out_valid clears on the handshake edge unless a new result loads on the same edge. A simultaneous drain and accept is allowed, giving full throughput for single-cycle ops.
- MUL completion while the output register is still occupied cannot occur, because In_ready gating guarantees the register drained before MUL started.
- Reset (any time, including mid-MUL):
  - Output state: Out=0, all flags 0, Err=0, Out_valid=0.
  - Internal state: state=IDLE, counter=0.
  - An in-flight MUL is discarded; no result is produced.

## Timing
- Single-cycle ops: accept at edge N → Out_valid=1 after edge N (latency 1).
- MUL: accept at edge N → Out_valid=1 after edge N+WIDTH+1.
- In_ready=0 from accept through completion.
- Back-to-back single-cycle ops with Out_ready=1: one result per cycle.
- During Rst_n low: In_ready=1, Out_valid=0.

## Structure
- `alu_pkg`:
  - Sel opcode localparams (OP_AND … OP_MUL).
  - FSM state typedef (IDLE, MUL).
  - Flag struct {Zero, Carry, Overflow, Negative, Err}.
- One sub-module, `alu_mul_iter`:
  - Shift-add multiplier with start/busy/done, product and high-nonzero outputs, WIDTH-parameterised.
  - Top holds the combinational op decode, FSM, and output register.

## Test plan
- WIDTH=8, ADD 0x55+0xAA → Out=0xFF, Negative=1, Carry=0, Overflow=0, Out_valid one cycle after accept. ADD 0x7F+0x01 → 0x80, Overflow=1.
- SUB 0xFF−0xFF → Out=0x00, Zero=1, Carry=1. SUB 0x00−0x01 → 0xFF, Carry=0. SLT A=0x80,B=0x01 → 0x01.
- SRA 0x80 by 3 → 0xF0; SRL 0x80 by 3 → 0x10; SLL 0x01 by 7 → 0x80, Negative=1. NOR 0xCC,0xAA → 0x11.
- MUL 0x0F×0x11 → 0xFF, Carry=0, Out_valid 9 cycles after accept, In_ready low throughout. MUL 0x10×0x10 → 0x00, Zero=1, Carry=1.
- AND 0xCC&0xAA with Out_ready low 3 cycles → Out=0x88 stable, In_ready=0. A second op presented meanwhile is accepted on the drain edge; its result appears the next cycle.
- Sel=1111 → Out=0, Err=1, Zero=1. Rst_n asserted mid-MUL → Out_valid=0, all outputs 0, In_ready=1, no late result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, FSM state type and flag payload for alu_seq.
package alu_pkg;

  localparam int unsigned SEL_W = 4;

  localparam logic [SEL_W-1:0] OP_AND = 4'b0000;
  localparam logic [SEL_W-1:0] OP_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] OP_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] OP_SLL = 4'b0011;
  localparam logic [SEL_W-1:0] OP_SRL = 4'b0100;
  localparam logic [SEL_W-1:0] OP_SRA = 4'b0101;
  localparam logic [SEL_W-1:0] OP_SUB = 4'b0110;
  localparam logic [SEL_W-1:0] OP_SLT = 4'b0111;
  localparam logic [SEL_W-1:0] OP_MUL = 4'b1000;
  localparam logic [SEL_W-1:0] OP_NOR = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports: start loads a/b and arms a WIDTH-step counter; busy is high until the
// cycle after the last step; done_c marks that final cycle; product is the low
// WIDTH bits, hi_nz_c flags any nonzero high product bit.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] product,
  output logic             hi_nz_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;

  // Shift-add datapath; counter reaching zero ends the step phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= PW'(a);
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
      busy     <= 1'b1;
    end else if (busy) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done_c  = busy && (cnt_q == '0);
  assign product = acc_q[WIDTH-1:0];
  assign hi_nz_c = |acc_q[PW-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-generic ALU with flags and an iterative multiply.
// Ports: in_valid/in_ready accept a, b, sel; out_valid/out_ready drain the
// registered result out with zero/carry/overflow/negative/err flags.
// in_ready is combinational from state and the output handshake only.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W1  = WIDTH + 1;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flags_q, flags_d;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_product;
  logic             mul_hi_nz_c;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;

  logic             load;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic             ld_ovf;
  logic             ld_err;

  assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done_c  (mul_done_c),
    .product (mul_product),
    .hi_nz_c (mul_hi_nz_c)
  );

  // Single-cycle op decode; SUB carry is the carry-out of a + ~b + 1.
  always_comb begin
    shamt     = b[SHW-1:0];
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} + {1'b0, ~b} + W1'(1);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (sel)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state and output-register load selection.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    out_d     = out_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    load      = 1'b0;
    ld_res    = '0;
    ld_carry  = 1'b0;
    ld_ovf    = 1'b0;
    ld_err    = 1'b0;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            load     = 1'b1;
            ld_res   = alu_res;
            ld_carry = alu_carry;
            ld_ovf   = alu_ovf;
            ld_err   = alu_err;
          end
        end
      end
      MUL: begin
        if (mul_done_c) begin
          load     = 1'b1;
          ld_res   = mul_product;
          ld_carry = mul_hi_nz_c;
          state_d  = IDLE;
        end else if (!mul_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new result wins over a same-edge drain.
    if (load) begin
      valid_d          = 1'b1;
      out_d            = ld_res;
      flags_d.zero     = (ld_res == '0);
      flags_d.carry    = ld_carry;
      flags_d.overflow = ld_ovf;
      flags_d.negative = ld_res[WIDTH-1];
      flags_d.err      = ld_err;
    end
  end

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign negative  = flags_q.negative;
  assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         zero, carry, overflow, negative, err;
  logic [4:0]   flags_w;

  int checks = 0;
  int errors = 0;

  // Model: output register contents and remaining multiply cycles.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_out = '0;
  logic [4:0]   m_flags = '0;
  int           mul_left = 0;
  logic [W+4:0] pend = '0;

  always #5 clk = ~clk;

  assign flags_w = {zero, carry, overflow, negative, err};

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .err       (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {zero, carry, overflow, negative, err, result}.
  function automatic logic [W+4:0] ref_op(input logic [3:0] s, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint ux, uy, sx, sy, full, smax, smin, lim;
    int sh;
    logic c, v, e;
    logic [W-1:0] r;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lim  = longint'(1) << W;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    sh = int'(y) % W;
    c = 1'b0; v = 1'b0; e = 1'b0; r = '0;
    case (s)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin
        full = ux + uy; r = W'(full); c = (full >= lim);
        full = sx + sy; v = (full > smax) || (full < smin);
      end
      4'b0110: begin
        full = ux - uy; r = W'(full); c = (ux >= uy);
        full = sx - sy; v = (full > smax) || (full < smin);
      end
      4'b0111: r = (sx < sy) ? W'(1) : W'(0);
      4'b0011: r = W'(ux << sh);
      4'b0100: r = W'(ux >> sh);
      4'b0101: r = W'(sx >>> sh);
      4'b1000: begin
        full = ux * uy; r = W'(full); c = ((full >> W) != 0);
      end
      default: e = 1'b1;
    endcase
    return {(r == '0), c, v, r[W-1], e, r};
  endfunction

  // Advance the model across the coming rising edge.
  task automatic model_step(input logic v, input logic [3:0] s, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic ordy);
    logic acc;
    logic [W+4:0] r;
    acc = v && (mul_left == 0) && (!m_valid || ordy);
    if (m_valid && ordy) m_valid = 1'b0;
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        m_valid = 1'b1;
        {m_flags, m_out} = pend;
      end
    end
    if (acc) begin
      r = ref_op(s, x, y);
      if (s == 4'b1000) begin
        mul_left = W + 1;
        pend = r;
      end else begin
        m_valid = 1'b1;
        {m_flags, m_out} = r;
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, (mul_left == 0) && (!m_valid || out_ready));
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out", out, m_out);
      chk("flags", flags_w, m_flags);
    end
  endtask

  // Called at a falling edge: drive, step model, cross a rising edge, compare.
  task automatic cycle(input logic v, input logic [3:0] s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ordy);
    in_valid = v; sel = s; a = x; b = y; out_ready = ordy;
    model_step(v, s, x, y, ordy);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, '0, '0, ordy);
  endtask

  task automatic op_pin(input string nm, input logic [3:0] s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eo, input logic [4:0] ef);
    cycle(1'b1, s, x, y, 1'b1);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_out"}, out, eo);
    chk({nm, "_flags"}, flags_w, ef);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out"}, out, 0);
    chk({nm, "_flags"}, flags_w, 0);
  endtask

  initial begin
    logic [3:0]   ops [12];
    logic [W-1:0] edges [4];
    logic [W-1:0] x, y;
    ops   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'h9, 4'hF};
    edges = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    @(negedge clk);
    @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Flags order: {zero, carry, overflow, negative, err}.
    op_pin("add_55_aa", 4'b0010, 8'h55, 8'hAA, 8'hFF, 5'b00010);
    op_pin("add_7f_01", 4'b0010, 8'h7F, 8'h01, 8'h80, 5'b00110);
    op_pin("sub_ff_ff", 4'b0110, 8'hFF, 8'hFF, 8'h00, 5'b11000);
    op_pin("sub_00_01", 4'b0110, 8'h00, 8'h01, 8'hFF, 5'b00010);
    op_pin("slt_80_01", 4'b0111, 8'h80, 8'h01, 8'h01, 5'b00000);
    op_pin("sra_80_3",  4'b0101, 8'h80, 8'h03, 8'hF0, 5'b00010);
    op_pin("srl_80_3",  4'b0100, 8'h80, 8'h03, 8'h10, 5'b00000);
    op_pin("sll_01_7",  4'b0011, 8'h01, 8'h07, 8'h80, 5'b00010);
    op_pin("nor_cc_aa", 4'b1100, 8'hCC, 8'hAA, 8'h11, 5'b00000);

    cycle(1'b1, 4'b1000, 8'h0F, 8'h11, 1'b1);
    chk("mul1_in_ready", in_ready, 0);
    idle(8, 1'b1);
    chk("mul1_early", out_valid, 0);
    idle(1, 1'b1);
    chk("mul1_valid", out_valid, 1);
    chk("mul1_out", out, 8'hFF);
    chk("mul1_flags", flags_w, 5'b00010);

    cycle(1'b1, 4'b1000, 8'h10, 8'h10, 1'b1);
    idle(9, 1'b1);
    chk("mul2_out", out, 8'h00);
    chk("mul2_flags", flags_w, 5'b11000);
    idle(1, 1'b1);

    cycle(1'b1, 4'b0000, 8'hCC, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0001, 8'h0F, 8'hF0, 1'b0);
      chk("stall_out", out, 8'h88);
      chk("stall_in_ready", in_ready, 0);
    end
    cycle(1'b1, 4'b0001, 8'h0F, 8'hF0, 1'b1);
    chk("drain_accept_valid", out_valid, 1);
    chk("drain_accept_out", out, 8'hFF);

    op_pin("sel_f", 4'b1111, 8'h12, 8'h34, 8'h00, 5'b10001);

    cycle(1'b1, 4'b1000, 8'hFF, 8'hFF, 1'b1);
    idle(3, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_mul_reset");
    m_valid = 1'b0;
    mul_left = 0;
    @(negedge clk);
    @(negedge clk);
    reset_checks("mid_mul_hold");
    rst_n = 1'b1;
    idle(12, 1'b1);
    chk("no_late_result", out_valid, 0);

    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      cycle($urandom_range(0, 3) != 0, ops[$urandom_range(0, 11)], x, y,
            $urandom_range(0, 3) != 0);
    end
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
